// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl
//
// Memory-stage controller between the EXE-to-MEM and MEM-to-WB pipeline
// registers. A 32-bit load or store is carried out as two half-word accesses
// to an external 16-bit SRAM: low half first, then high half. Each half-word
// access holds the SRAM pins steady for WAIT_CYCLES cycles. While an access
// is in flight `ready` is low so the whole pipeline freezes.
//
// Parameters
//   WAIT_CYCLES : cycles each half-word access is held on the pins (1..15)
//   BASE_ADDR   : byte address that maps to SRAM word 0
//   SRAM_AW     : SRAM half-word address width
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous reset, active low
//   mem_read     in   load request from the EXE-to-MEM register
//   mem_write    in   store request (wins over mem_read when both are set)
//   addr         in   32-bit byte address (ALU result)
//   wdata        in   32-bit store data
//   rdata        out  32-bit load result, valid while ready=1 in DONE
//   ready        out  1 = pipeline may advance, 0 = freeze
//   sram_addr    out  SRAM half-word address
//   sram_we_n    out  SRAM write enable, active low
//   sram_dq_out  out  data driven onto the SRAM bus for stores
//   sram_dq_oe   out  1 = drive sram_dq_out onto the bus
//   sram_dq_in   in   data read back from the SRAM bus
// ---------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    // Counter value loaded on entry to each half-word phase; the phase
    // ends on the cycle the counter reads zero, giving WAIT_CYCLES cycles.
    localparam logic [3:0] LP_RELOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;

    // Copies of the request taken in IDLE; the pipeline inputs are not
    // looked at again until the controller is back in IDLE.
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_store;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_start;
    logic        w_phase_end;
    logic [31:0] w_word_idx;
    logic [SRAM_AW-1:0] w_lo_addr;
    logic [SRAM_AW-1:0] w_hi_addr;

    assign w_req       = mem_read | mem_write;
    assign w_start     = (r_state == S_IDLE) && w_req;
    assign w_phase_end = (r_cnt == 4'd0);

    // Word index is formed on the full 32 bits; the half-word address then
    // simply drops whatever does not fit, so out-of-range addresses wrap.
    assign w_word_idx = (r_addr - BASE_ADDR) >> 2;
    assign w_lo_addr  = SRAM_AW'({w_word_idx, 1'b0});
    assign w_hi_addr  = SRAM_AW'({w_word_idx, 1'b1});

    assign rdata = r_rdata;

    // -----------------------------------------------------------------------
    // State and wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Request capture. Only consumed while in LO/HI, which cannot be reached
    // without passing through this load, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_store <= mem_write;
        end
    end

    // Load result. Each half is captured on the edge that closes its phase,
    // so the SRAM has had the full WAIT_CYCLES to respond. Reset clears it,
    // which also discards a half-completed load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (!r_store && w_phase_end) begin
            if (r_state == S_LO) begin
                r_rdata[15:0] <= sram_dq_in;
            end else if (r_state == S_HI) begin
                r_rdata[31:16] <= sram_dq_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        ready        = 1'b0;
        sram_addr    = '0;
        sram_we_n    = 1'b1;
        sram_dq_out  = 16'd0;
        sram_dq_oe   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Non-memory instructions pass straight through.
                ready = !w_req;
                if (w_req) begin
                    w_next_state = S_LO;
                    w_next_cnt   = LP_RELOAD;
                end
            end

            S_LO: begin
                sram_addr = w_lo_addr;
                if (r_store) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[15:0];
                end
                if (w_phase_end) begin
                    w_next_state = S_HI;
                    w_next_cnt   = LP_RELOAD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end

            S_HI: begin
                sram_addr = w_hi_addr;
                if (r_store) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[31:16];
                end
                if (w_phase_end) begin
                    w_next_state = S_DONE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end

            S_DONE: begin
                // The pipeline advances on the edge that ends this cycle, so
                // the next instruction's request is seen fresh in IDLE and the
                // one just served is never repeated.
                ready        = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // W=3 instance
    logic        rd3 = 1'b0, wr3 = 1'b0;
    logic [31:0] ad3 = 32'd0, wd3 = 32'd0;
    logic [31:0] rdata3;
    logic        ready3, we3, oe3;
    logic [17:0] sa3;
    logic [15:0] dqo3, dqi3;

    // W=1 instance
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] ad1 = 32'd0, wd1 = 32'd0;
    logic [31:0] rdata1;
    logic        ready1, we1, oe1;
    logic [17:0] sa1;
    logic [15:0] dqo1, dqi1;

    mem_sram_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024), .SRAM_AW(18)) u3 (
        .clk(clk), .rst(rst), .mem_read(rd3), .mem_write(wr3), .addr(ad3),
        .wdata(wd3), .rdata(rdata3), .ready(ready3), .sram_addr(sa3),
        .sram_we_n(we3), .sram_dq_out(dqo3), .sram_dq_oe(oe3), .sram_dq_in(dqi3)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_AW(18)) u1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(ad1),
        .wdata(wd1), .rdata(rdata1), .ready(ready1), .sram_addr(sa1),
        .sram_we_n(we1), .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1)
    );

    // SRAM models: never-written locations read back {A5, address}.
    logic [15:0] mem3 [0:63];
    logic        wv3  [0:63] = '{default: 1'b0};
    logic [15:0] mem1 [0:63];
    logic        wv1  [0:63] = '{default: 1'b0};

    always @(posedge clk) begin
        if (!we3) begin
            mem3[sa3[5:0]] <= dqo3;
            wv3[sa3[5:0]]  <= 1'b1;
        end
        if (!we1) begin
            mem1[sa1[5:0]] <= dqo1;
            wv1[sa1[5:0]]  <= 1'b1;
        end
    end

    assign dqi3 = wv3[sa3[5:0]] ? mem3[sa3[5:0]] : {8'hA5, 2'b00, sa3[5:0]};
    assign dqi1 = wv1[sa1[5:0]] ? mem1[sa1[5:0]] : {8'hA5, 2'b00, sa1[5:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One complete W=3 access starting in an IDLE cycle (cycle 0).
    // Returns in the IDLE cycle after DONE with requests dropped.
    task automatic op3(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [17:0] elo,
                       input logic [17:0] ehi, input logic est,
                       input logic [31:0] erd, input logic [15:0] dlo,
                       input logic [15:0] dhi, input string tag);
        rd3 = r; wr3 = w; ad3 = a; wd3 = d;
        #1;
        chk($sformatf("%s c0 ready", tag), ready3, 0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) begin
                // Inputs change mid-access; the latched copies must be used.
                ad3 = 32'hFFFF_FFF0;
                wd3 = 32'h1111_2222;
            end
            if (c == 7) begin
                chk($sformatf("%s c7 ready", tag), ready3, 1);
                chk($sformatf("%s c7 rdata", tag), rdata3, erd);
                chk($sformatf("%s c7 we_n", tag), we3, 1);
                chk($sformatf("%s c7 oe", tag), oe3, 0);
            end else begin
                chk($sformatf("%s c%0d ready", tag, c), ready3, 0);
                chk($sformatf("%s c%0d addr", tag, c), sa3, (c <= 3) ? elo : ehi);
                chk($sformatf("%s c%0d we_n", tag, c), we3, !est);
                chk($sformatf("%s c%0d oe", tag, c), oe3, est);
                chk($sformatf("%s c%0d dq", tag, c), dqo3,
                    est ? ((c <= 3) ? dlo : dhi) : 16'h0000);
            end
        end
        rd3 = 1'b0; wr3 = 1'b0;
        step();
        chk($sformatf("%s c8 ready", tag), ready3, 1);
    endtask

    initial begin
        logic [7:0] exp_rdy;
        int rdy_cnt;
        int wr_cnt;

        // Reset held with a read request pending
        rst = 1'b0;
        rd3 = 1'b1; ad3 = 32'd1036;
        step();
        chk("rst rdata", rdata3, 32'd0);
        chk("rst we_n", we3, 1);
        chk("rst oe", oe3, 0);
        chk("rst addr", sa3, 18'd0);
        chk("rst ready", ready3, 0);
        chk("rst dq", dqo3, 16'd0);
        step();
        chk("rst idle addr", sa3, 18'd0);
        chk("rst idle ready", ready3, 0);
        chk("rst u1 ready", ready1, 1);
        rst = 1'b1;

        // Read right after release: word 3 -> half-words 6,7 (unwritten)
        op3(1'b1, 1'b0, 32'd1036, 32'd0, 18'd6, 18'd7, 1'b0,
            32'hA507_A506, 16'h0, 16'h0, "rstrd");

        // Store W=3
        op3(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 18'd2, 18'd3, 1'b1,
            32'hA507_A506, 16'hBEEF, 16'hDEAD, "st");
        chk("st mem lo", mem3[2], 16'hBEEF);
        chk("st mem hi", mem3[3], 16'hDEAD);

        // Load W=3 from the same address
        op3(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 18'd3, 1'b0,
            32'hDEAD_BEEF, 16'h0, 16'h0, "ld");

        // Both requests: store wins, rdata untouched
        op3(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 18'd4, 18'd5, 1'b1,
            32'hDEAD_BEEF, 16'hF00D, 16'hCAFE, "both");
        chk("both mem lo", mem3[4], 16'hF00D);
        chk("both mem hi", mem3[5], 16'hCAFE);

        // Reset in cycle 4 of a W=3 load
        rd3 = 1'b1; ad3 = 32'd1036;
        #1;
        for (int i = 0; i < 4; i++) step();
        chk("abort partial rdata", rdata3, 32'hDEAD_A506);
        chk("abort hi addr", sa3, 18'd7);
        rst = 1'b0;
        #1;
        chk("abort rdata", rdata3, 32'd0);
        chk("abort addr", sa3, 18'd0);
        chk("abort ready", ready3, 0);
        chk("abort we_n", we3, 1);
        step();
        chk("abort idle addr", sa3, 18'd0);
        rst = 1'b1;
        op3(1'b1, 1'b0, 32'd1036, 32'd0, 18'd6, 18'd7, 1'b0,
            32'hA507_A506, 16'h0, 16'h0, "postabort");

        // Back-to-back store then load at 1024, W=1
        exp_rdy = 8'b1000_1000;
        rdy_cnt = 0;
        wr_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                wr1 = 1'b1; rd1 = 1'b0; ad1 = 32'd1024; wd1 = 32'h0BAD_F00D;
            end else begin
                wr1 = 1'b0; rd1 = 1'b1; ad1 = 32'd1024; wd1 = 32'd0;
            end
            #1;
            chk($sformatf("b2b c%0d ready", c), ready1, exp_rdy[c]);
            chk($sformatf("b2b c%0d we_n", c), we1, (c == 1 || c == 2) ? 1'b0 : 1'b1);
            if (c == 1 || c == 5) chk($sformatf("b2b c%0d addr", c), sa1, 18'd0);
            if (c == 2 || c == 6) chk($sformatf("b2b c%0d addr", c), sa1, 18'd1);
            if (c == 1) chk("b2b c1 dq", dqo1, 16'hF00D);
            if (c == 2) chk("b2b c2 dq", dqo1, 16'h0BAD);
            if (c == 7) chk("b2b c7 rdata", rdata1, 32'h0BAD_F00D);
            if (ready1) rdy_cnt++;
            if (!we1) wr_cnt++;
            step();
        end
        rd1 = 1'b0; wr1 = 1'b0;
        #1;
        chk("b2b idle ready", ready1, 1);
        chk("b2b ready count", rdy_cnt, 2);
        chk("b2b write cycles", wr_cnt, 2);
        chk("b2b mem lo", mem1[0], 16'hF00D);
        chk("b2b mem hi", mem1[1], 16'h0BAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
